// File: rtl/drops_btn_conditioner.sv
// drops_btn_conditioner
//   Input conditioning ahead of the drops game core. Each raw push-button is
//   synchronised, debounced, and turned into clean levels plus single-cycle
//   press/release pulses. A per-button repeat FSM generates btn_step pulses
//   (press, then auto-repeat while held) that move the catcher.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_raw      asynchronous raw buttons, active high
//   btn_level    debounced level
//   btn_press    1-cycle pulse when the debounced level rises
//   btn_release  1-cycle pulse when the debounced level falls
//   btn_step     1-cycle pulse on press and on every auto-repeat tick

module drops_btn_conditioner #(
    parameter int unsigned N_BTN        = 2,
    parameter int unsigned DEBOUNCE_CYC = 2000,
    parameter int unsigned REPEAT_DELAY = 250000,
    parameter int unsigned REPEAT_RATE  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_step
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_TERM    = DB_W'(DEBOUNCE_CYC);
    localparam logic [RPT_W-1:0] DELAY_TERM = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RATE_TERM  = RPT_W'(REPEAT_RATE);
    localparam bit               RPT_EN     = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat,
        StHold
    } rpt_state_e;

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] step_q, step_d;

    logic [DB_W-1:0]  db_cnt_q  [N_BTN];
    logic [DB_W-1:0]  db_cnt_d  [N_BTN];
    logic [RPT_W-1:0] rpt_cnt_q [N_BTN];
    logic [RPT_W-1:0] rpt_cnt_d [N_BTN];
    rpt_state_e       state_q   [N_BTN];
    rpt_state_e       state_d   [N_BTN];

    // Debounce: the synchronised input must disagree with the accepted level
    // on DEBOUNCE_CYC+1 consecutive edges before the level follows it.
    always_comb begin
        for (int b = 0; b < int'(N_BTN); b++) begin
            level_d[b]  = level_q[b];
            db_cnt_d[b] = '0;
            if (sync2_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_TERM) begin
                    level_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    // Repeat FSM next-state; a release overrides any terminal-count step.
    always_comb begin
        step_d = '0;
        for (int b = 0; b < int'(N_BTN); b++) begin
            state_d[b]   = state_q[b];
            rpt_cnt_d[b] = rpt_cnt_q[b];
            if (release_d[b]) begin
                state_d[b]   = StIdle;
                rpt_cnt_d[b] = '0;
            end else begin
                case (state_q[b])
                    StIdle: begin
                        if (press_d[b]) begin
                            step_d[b]    = 1'b1;
                            rpt_cnt_d[b] = '0;
                            state_d[b]   = RPT_EN ? StDelay : StHold;
                        end
                    end
                    StDelay: begin
                        if (rpt_cnt_q[b] == DELAY_TERM) begin
                            step_d[b]    = 1'b1;
                            rpt_cnt_d[b] = '0;
                            state_d[b]   = StRepeat;
                        end else begin
                            rpt_cnt_d[b] = rpt_cnt_q[b] + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (rpt_cnt_q[b] == RATE_TERM) begin
                            step_d[b]    = 1'b1;
                            rpt_cnt_d[b] = '0;
                        end else begin
                            rpt_cnt_d[b] = rpt_cnt_q[b] + 1'b1;
                        end
                    end
                    StHold: begin
                        rpt_cnt_d[b] = '0;
                    end
                    default: begin
                        state_d[b]   = StIdle;
                        rpt_cnt_d[b] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            step_q    <= '0;
            for (int b = 0; b < int'(N_BTN); b++) begin
                db_cnt_q[b]  <= '0;
                rpt_cnt_q[b] <= '0;
                state_q[b]   <= StIdle;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            for (int b = 0; b < int'(N_BTN); b++) begin
                db_cnt_q[b]  <= db_cnt_d[b];
                rpt_cnt_q[b] <= rpt_cnt_d[b];
                state_q[b]   <= state_d[b];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_step    = step_q;

endmodule

// File: tb/tb_drops_btn_conditioner.sv
// tb_drops_btn_conditioner
//   Two instances share the stimulus: one with auto-repeat (delay 8, rate 3)
//   and one with repeat disabled. A cycle-level reference model predicts every
//   output from arithmetic on edge indices: a level flips once the
//   synchronised input has differed for DEBOUNCE_CYC+1 edges, and steps fall
//   at press offsets 0 and DELAY+1+m*(RATE+1) while the level stays high.

module tb_drops_btn_conditioner;

    localparam int unsigned N  = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned RR = 3;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] raw   = '0;

    logic [N-1:0] level, press, rel, step;
    logic [N-1:0] nr_level, nr_press, nr_rel, nr_step;

    drops_btn_conditioner #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (D),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (raw),
        .btn_level   (level),
        .btn_press   (press),
        .btn_release (rel),
        .btn_step    (step)
    );

    drops_btn_conditioner #(
        .N_BTN        (N),
        .DEBOUNCE_CYC (D),
        .REPEAT_DELAY (0),
        .REPEAT_RATE  (RR)
    ) dut_nr (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (raw),
        .btn_level   (nr_level),
        .btn_press   (nr_press),
        .btn_release (nr_rel),
        .btn_step    (nr_step)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int           k = 0;
    logic [N-1:0] m_s1 = '0, m_s2 = '0;
    logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0, m_step = '0, m_step_nr = '0;
    int           last_eq [N] = '{0, 0};
    int           pcyc    [N] = '{-1, -1};

    task automatic model_edge();
        logic [N-1:0] sync;
        int d;
        k++;
        if (reset) begin
            m_s1 = '0; m_s2 = '0;
            m_level = '0; m_press = '0; m_rel = '0; m_step = '0; m_step_nr = '0;
            for (int b = 0; b < int'(N); b++) begin
                last_eq[b] = k;
                pcyc[b]    = -1;
            end
        end else begin
            sync = m_s2;
            m_s2 = m_s1;
            m_s1 = raw;
            for (int b = 0; b < int'(N); b++) begin
                m_press[b] = 1'b0;
                m_rel[b]   = 1'b0;
                if (sync[b] == m_level[b]) begin
                    last_eq[b] = k;
                end else if (k - last_eq[b] >= int'(D) + 1) begin
                    m_level[b] = sync[b];
                    m_press[b] = sync[b];
                    m_rel[b]   = ~sync[b];
                    last_eq[b] = k;
                end
                if (m_press[b]) begin
                    pcyc[b]      = k;
                    m_step[b]    = 1'b1;
                    m_step_nr[b] = 1'b1;
                end else if (m_level[b]) begin
                    d = k - pcyc[b];
                    m_step[b]    = (d >= int'(RD) + 1) && ((d - int'(RD) - 1) % (int'(RR) + 1) == 0);
                    m_step_nr[b] = 1'b0;
                end else begin
                    m_step[b]    = 1'b0;
                    m_step_nr[b] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        check_eq("level",      32'(level),    32'(m_level));
        check_eq("press",      32'(press),    32'(m_press));
        check_eq("release",    32'(rel),      32'(m_rel));
        check_eq("step",       32'(step),     32'(m_step));
        check_eq("nr_level",   32'(nr_level), 32'(m_level));
        check_eq("nr_press",   32'(nr_press), 32'(m_press));
        check_eq("nr_release", 32'(nr_rel),   32'(m_rel));
        check_eq("nr_step",    32'(nr_step),  32'(m_step_nr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n, rise_at, press_cnt, run, max_run, hits, p;
        int steps[$];

        // 1: reset, then a clean press on bit 0
        reset = 1'b1; raw = '0;
        ticks(3);
        check_eq("t1_reset_outs", {level, press, rel, step}, 32'd0);
        reset = 1'b0; raw = 2'b01;
        rise_at = -1; press_cnt = 0; run = 0; max_run = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (level[0] && rise_at < 0) rise_at = i;
            if (press[0]) press_cnt++;
            run = step[0] ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check_eq("t1_latency", rise_at, 6);
        check_eq("t1_press_cnt", press_cnt, 1);
        check_eq("t1_step_width", max_run, 1);
        raw = '0;
        ticks(20);

        // 2: bounce rejected
        hits = 0;
        for (int i = 0; i < 19; i++) begin
            raw[0] = (i < 4) ? ((i % 2) == 0) : 1'b0;
            tick();
            if (level[0] || press[0] || step[0]) hits++;
        end
        check_eq("t2_bounce", hits, 0);

        // 3: long hold on bit 1 with auto-repeat
        raw = 2'b10;
        p = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (press[1]) p = i;
            if (step[1]) steps.push_back(i);
        end
        check_eq("t3_press_seen", 32'(p >= 0), 32'd1);
        check_eq("t3_nsteps_ge5", 32'(steps.size() >= 5), 32'd1);
        if (steps.size() >= 5) begin
            check_eq("t3_step0", steps[0] - p, 0);
            check_eq("t3_step1", steps[1] - p, 9);
            check_eq("t3_step2", steps[2] - p, 13);
            check_eq("t3_step3", steps[3] - p, 17);
            check_eq("t3_step4", steps[4] - p, 21);
        end
        raw = 2'b00;
        n = 0;
        tick();
        while (!rel[1] && n < 40) begin
            tick();
            n++;
        end
        check_eq("t3_release_lat", n, 6);
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (step[1] || rel[1]) hits++;
        end
        check_eq("t3_quiet_after_rel", hits, 0);

        // 4: simultaneous press on both buttons
        raw = 2'b11;
        n = 0;
        tick();
        while (press == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check_eq("t4_press_both", 32'(press), 32'd3);
        check_eq("t4_step_both", 32'(step), 32'd3);

        // 5: reset while repeating, button still held afterwards
        ticks(14);
        reset = 1'b1;
        tick();
        check_eq("t5_rst_outs", {level, press, rel, step}, 32'd0);
        check_eq("t5_rst_outs_nr", {nr_level, nr_press, nr_rel, nr_step}, 32'd0);
        reset = 1'b0;
        n = 0;
        tick();
        while (press == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check_eq("t5_repress_lat", n, 6);
        check_eq("t5_repress_val", 32'(press), 32'd3);
        raw = '0;
        ticks(20);

        // 6: repeat disabled gives exactly one step over a long hold
        raw = 2'b01;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (nr_step[0]) hits++;
        end
        check_eq("t6_single_step", hits, 1);
        raw = '0;
        ticks(20);

        // Random phase: held random patterns with occasional resets
        for (int it = 0; it < 300; it++) begin
            raw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) begin
                reset = 1'b1;
                ticks(int'($urandom_range(1, 2)));
                reset = 1'b0;
            end
            ticks(int'($urandom_range(1, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
